// File: rtl/median_window_feeder.sv
// Raster-to-3x3 window feeder for the MEDIAN stage.
// Accepts an 8-bit raster pixel stream and builds 3x3 neighbourhoods from two
// line buffers and a shift window. Each interior window is sent as a 9-cycle
// serial burst on DSI/DI. The pixel source is stalled until MEDIAN answers
// with DSO, or until the wait timer expires, which sets the sticky ERR flag.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_ACCEPT | PIX_READY high, taking pixels; valid window -> ST_SEND
// ST_SEND   | DSI high, DI = w[k], k = 0..8, no pixels taken
// ST_WAIT   | waiting for DSO; wait timer counts down toward abort
module median_window_feeder #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int WAIT_MAX = 63
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       PIX_VALID,
    input  logic [7:0] PIX_IN,
    output logic       PIX_READY,
    output logic       DSI,
    output logic [7:0] DI,
    input  logic       DSO,
    output logic       FRAME_DONE,
    output logic       ERR
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    // Timer holds WAIT_MAX-1 down to 0, so WAIT lasts exactly WAIT_MAX cycles.
    localparam int TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [3:0]    k_q, k_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pix_ready_q, pix_ready_d;
    logic          dsi_q, dsi_d;
    logic [7:0]    di_q, di_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    // Window is row-major, oldest line first: index r*3+c.
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb0_d [IMG_W];
    logic [7:0]    lb1_q [IMG_W];
    logic [7:0]    lb1_d [IMG_W];

    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          win_valid;
    logic [3:0]    k_nxt;

    // PIX_READY is only ever high in ST_ACCEPT, so it alone qualifies a transfer.
    assign accept    = PIX_VALID && pix_ready_q;
    assign last_col  = (col_q == CW'(IMG_W - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign win_valid = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign k_nxt     = k_q + 4'd1;

    // Shift window and roll line buffers on every accepted pixel.
    always_comb begin
        win_d = win_q;
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3 + 0] = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2]     = lb1_q[col_q];
            win_d[5]     = lb0_q[col_q];
            win_d[8]     = PIX_IN;
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = PIX_IN;
        end
    end

    // Next-state, raster position, burst index, wait timer and registered outputs.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        k_d          = k_q;
        timer_d      = timer_q;
        pix_ready_d  = 1'b0;
        dsi_d        = 1'b0;
        di_d         = 8'd0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        case (state_q)
            ST_ACCEPT: begin
                pix_ready_d = 1'b1;
                if (accept) begin
                    col_d        = last_col ? '0 : col_q + 1'b1;
                    if (last_col) begin
                        row_d = last_row ? '0 : row_q + 1'b1;
                    end
                    frame_done_d = last_col && last_row;
                    if (win_valid) begin
                        // First window element goes out on the very next cycle,
                        // taken from the window as it is after this shift.
                        state_d     = ST_SEND;
                        k_d         = 4'd0;
                        dsi_d       = 1'b1;
                        di_d        = win_d[0];
                        pix_ready_d = 1'b0;
                    end
                end
            end
            ST_SEND: begin
                if (k_q == 4'd8) begin
                    state_d = ST_WAIT;
                    timer_d = TW'(WAIT_MAX - 1);
                end else begin
                    k_d   = k_nxt;
                    dsi_d = 1'b1;
                    di_d  = win_q[k_nxt];
                end
            end
            ST_WAIT: begin
                if (DSO) begin
                    state_d     = ST_ACCEPT;
                    pix_ready_d = 1'b1;
                end else if (timer_q == '0) begin
                    err_d       = 1'b1;
                    state_d     = ST_ACCEPT;
                    pix_ready_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_ACCEPT;
            col_q        <= '0;
            row_q        <= '0;
            k_q          <= 4'd0;
            timer_q      <= '0;
            pix_ready_q  <= 1'b0;
            dsi_q        <= 1'b0;
            di_q         <= 8'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            k_q          <= k_d;
            timer_q      <= timer_d;
            pix_ready_q  <= pix_ready_d;
            dsi_q        <= dsi_d;
            di_q         <= di_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Pixel storage is not reset; only interior windows of a fresh frame are emitted.
    always_ff @(posedge CLK) begin
        win_q <= win_d;
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
    end

    assign PIX_READY  = pix_ready_q;
    assign DSI        = dsi_q;
    assign DI         = di_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR        = err_q;

endmodule
